// File: rtl/riskow_bus_pkg.sv
// rtl/riskow_bus_pkg.sv - shared types and constants for the CPU bus arbiter
package riskow_bus_pkg;

  localparam int WAIT_CNT_W = 4;
  localparam int BUS_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } busState_t;

  typedef enum logic {
    GRANT_FETCH,
    GRANT_DATA
  } grant_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester and memory-side signals of the CPU bus arbiter
interface bus_arbiter_if import riskow_bus_pkg::*; #(
  parameter int DATA_WIDTH = BUS_W
);

  logic                  ifReq;
  logic [DATA_WIDTH-1:0] ifAddr;
  logic [DATA_WIDTH-1:0] ifData;
  logic                  ifAck;
  logic                  dReq;
  logic                  dWe;
  logic [DATA_WIDTH-1:0] dAddr;
  logic [DATA_WIDTH-1:0] dWdata;
  logic [DATA_WIDTH-1:0] dRdata;
  logic                  dAck;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic [DATA_WIDTH-1:0] address;
  logic                  busWriteEnable;
  logic                  busy;

  // master: decoder requesters plus the memory read-data source
  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, dataIn,
    input  ifData, ifAck, dRdata, dAck, dataOut, address, busWriteEnable, busy
  );

  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, dataIn,
    output ifData, ifAck, dRdata, dAck, dataOut, address, busWriteEnable, busy
  );

endinterface

// File: rtl/bus_grant_select.sv
// rtl/bus_grant_select.sv - picks the winning requester; ARB_ROUND_ROBIN_EN enables alternating ties
module bus_grant_select import riskow_bus_pkg::*; (
  input  logic   ifReq,
  input  logic   dReq,
`ifdef ARB_ROUND_ROBIN_EN
  input  grant_t lastGrant,
`endif
  output logic   anyReq,
  output grant_t winner
);

  always_comb begin
    anyReq = ifReq | dReq;
    winner = GRANT_DATA;
`ifdef ARB_ROUND_ROBIN_EN
    if (ifReq && dReq) begin
      winner = (lastGrant == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
    end else if (ifReq) begin
      winner = GRANT_FETCH;
    end
`else
    if (ifReq && !dReq) begin
      winner = GRANT_FETCH;
    end
`endif
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares the CPU memory bus between fetch and load/store paths
// Optional macro ARB_ROUND_ROBIN_EN turns tie-breaking into round robin.
module bus_arbiter import riskow_bus_pkg::*; #(
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_WIDTH  = BUS_W
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  busState_t             state;
  logic [WAIT_CNT_W-1:0] waitCnt;
  grant_t                grantQ;
  logic [DATA_WIDTH-1:0] addressQ;
  logic [DATA_WIDTH-1:0] dataOutQ;
  logic                  bweQ;
  logic                  ifAckQ;
  logic                  dAckQ;
  logic [DATA_WIDTH-1:0] ifDataQ;
  logic [DATA_WIDTH-1:0] dRdataQ;
  logic                  busyQ;
  logic                  anyReq;
  grant_t                winner;
`ifdef ARB_ROUND_ROBIN_EN
  grant_t                lastGrant;
`endif

  bus_grant_select uGrant (
    .ifReq     (bus.ifReq),
    .dReq      (bus.dReq),
`ifdef ARB_ROUND_ROBIN_EN
    .lastGrant (lastGrant),
`endif
    .anyReq    (anyReq),
    .winner    (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      grantQ   <= GRANT_DATA;
      addressQ <= '0;
      dataOutQ <= '0;
      bweQ     <= 1'b0;
      ifAckQ   <= 1'b0;
      dAckQ    <= 1'b0;
      ifDataQ  <= '0;
      dRdataQ  <= '0;
      busyQ    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrant <= GRANT_DATA;
`endif
    end else begin
      ifAckQ <= 1'b0;
      dAckQ  <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            // the bus outputs themselves act as the latched request, so later
            // requester activity cannot disturb the access in flight
            grantQ   <= winner;
            addressQ <= (winner == GRANT_DATA) ? bus.dAddr : bus.ifAddr;
            dataOutQ <= (winner == GRANT_DATA && bus.dWe) ? bus.dWdata : '0;
            bweQ     <= (winner == GRANT_DATA) && bus.dWe;
            waitCnt  <= WAIT_LOAD;
            busyQ    <= 1'b1;
            state    <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            lastGrant <= winner;
`endif
          end
        end
        ACCESS: begin
          if (waitCnt == '0) begin
            if (grantQ == GRANT_DATA) begin
              dRdataQ <= bus.dataIn;
              dAckQ   <= 1'b1;
            end else begin
              ifDataQ <= bus.dataIn;
              ifAckQ  <= 1'b1;
            end
            bweQ     <= 1'b0;
            dataOutQ <= '0;
            state    <= RESP;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        RESP: begin
          busyQ <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busyQ <= 1'b0;
          bweQ  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.address        = addressQ;
  assign bus.dataOut        = dataOutQ;
  assign bus.busWriteEnable = bweQ;
  assign bus.ifAck          = ifAckQ;
  assign bus.dAck           = dAckQ;
  assign bus.ifData         = ifDataQ;
  assign bus.dRdata         = dRdataQ;
  assign bus.busy           = busyQ;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter (WAIT_CYCLES 1 and 0)
module tb_bus_arbiter;
  import riskow_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter_if #(.DATA_WIDTH(32)) bus0 ();
  bus_arbiter_if #(.DATA_WIDTH(32)) bus1 ();

  bus_arbiter #(.WAIT_CYCLES(1), .DATA_WIDTH(32)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  bus_arbiter #(.WAIT_CYCLES(0), .DATA_WIDTH(32)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_addr"},   bus0.address, 32'h0);
    checkVal({tag, "_dout"},   bus0.dataOut, 32'h0);
    checkVal({tag, "_bwe"},    32'(bus0.busWriteEnable), 32'h0);
    checkVal({tag, "_ifack"},  32'(bus0.ifAck), 32'h0);
    checkVal({tag, "_dack"},   32'(bus0.dAck), 32'h0);
    checkVal({tag, "_ifdata"}, bus0.ifData, 32'h0);
    checkVal({tag, "_drdata"}, bus0.dRdata, 32'h0);
    checkVal({tag, "_busy"},   32'(bus0.busy), 32'h0);
  endtask

  task automatic idleInputs();
    bus0.ifReq = 0; bus0.ifAddr = 0; bus0.dReq = 0; bus0.dWe = 0;
    bus0.dAddr = 0; bus0.dWdata = 0; bus0.dataIn = 0;
    bus1.ifReq = 0; bus1.ifAddr = 0; bus1.dReq = 0; bus1.dWe = 0;
    bus1.dAddr = 0; bus1.dWdata = 0; bus1.dataIn = 0;
  endtask

  // One transaction on dut0 (WAIT_CYCLES=1): ack expected in cycle 3 after the sampling edge
  task automatic runTxn(input bit isData, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] din, input string tag);
    int ackCnt = 0, ackCyc = 0, otherAck = 0, bweCyc = 0, badBus = 0;
    bit drop;
    logic [31:0] dataAtAck = 32'h0;
    @(posedge clk); #1;
    bus0.dataIn = din;
    if (isData) begin
      bus0.dReq = 1; bus0.dWe = we; bus0.dAddr = addr; bus0.dWdata = wdata;
    end else begin
      bus0.ifReq = 1; bus0.ifAddr = addr;
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      drop = isData ? bus0.dAck : bus0.ifAck;
      if (drop) begin
        ackCnt++;
        ackCyc = cyc;
        dataAtAck = isData ? bus0.dRdata : bus0.ifData;
      end
      if (isData ? bus0.ifAck : bus0.dAck) otherAck++;
      if (bus0.busWriteEnable) bweCyc++;
      if (cyc <= 2) begin
        if (bus0.address !== addr) badBus++;
        if (bus0.dataOut !== (we ? wdata : 32'h0)) badBus++;
        if (bus0.busWriteEnable !== we) badBus++;
        if (bus0.busy !== 1'b1) badBus++;
      end
      @(posedge clk); #1;
      if (drop) begin
        bus0.ifReq = 0; bus0.dReq = 0; bus0.dWe = 0;
      end
    end
    checkVal({tag, "_ackcnt"}, ackCnt, 1);
    checkVal({tag, "_ackcyc"}, ackCyc, 3);
    checkVal({tag, "_bwecyc"}, bweCyc, we ? 2 : 0);
    checkVal({tag, "_otherack"}, otherAck, 0);
    checkVal({tag, "_busbad"}, badBus, 0);
    checkVal({tag, "_rdata"}, dataAtAck, din);
    checkVal({tag, "_busyend"}, 32'(bus0.busy), 32'h0);
  endtask

  initial begin
    int nAck;
    int order[3];
    int ackAt[3];
    int expOrder[3];
    int rstAck;
    int ackAt1[2];
    logic [31:0] got1[2];
    logic [31:0] addrAt1;
    bit fSeen, dSeen, seen1;

    // 1. reset: outputs clear asynchronously, stay clear with no requests
    reset = 0;
    idleInputs();
    #2;
    reset = 1;
    bus0.ifReq = 1; bus0.ifAddr = $urandom; bus0.dReq = 1; bus0.dWe = 1;
    bus0.dAddr = $urandom; bus0.dWdata = $urandom; bus0.dataIn = $urandom;
    #1;
    checkAllZero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("rst_held");
    @(negedge clk);
    idleInputs();
    reset = 0;
    repeat (3) @(negedge clk);
    checkAllZero("post_rst");

    // 2. fetch read, 3. data store
    runTxn(0, 0, 32'h0000_0100, 32'h0, 32'h0050_0093, "fetch");
    runTxn(1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 32'hCAFE_F00D, "store");

    // 4. both requesters keep re-requesting for three grants
`ifdef ARB_ROUND_ROBIN_EN
    expOrder = '{0, 1, 0};
`else
    expOrder = '{1, 0, 1};
`endif
    nAck = 0;
    order = '{-1, -1, -1};
    ackAt = '{0, 0, 0};
    @(posedge clk); #1;
    bus0.ifReq = 1; bus0.ifAddr = 32'h300;
    bus0.dReq = 1; bus0.dWe = 0; bus0.dAddr = 32'h400; bus0.dataIn = 32'h5A5A_0000;
    @(posedge clk);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      fSeen = bus0.ifAck;
      dSeen = bus0.dAck;
      if (fSeen || dSeen) begin
        if (nAck < 3) begin
          order[nAck] = dSeen ? 1 : 0;
          ackAt[nAck] = cyc;
        end
        nAck++;
      end
      @(posedge clk); #1;
      if (nAck >= 3) begin
        bus0.ifReq = 0; bus0.dReq = 0;
      end else begin
        bus0.ifReq = !fSeen;
        bus0.dReq  = !dSeen;
      end
    end
    checkVal("tie_count", nAck, 3);
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("tie_order%0d", i), order[i], expOrder[i]);
      checkVal($sformatf("tie_ackcyc%0d", i), ackAt[i], 3 + 4 * i);
    end

    // 5. reset during the first ACCESS cycle of a store
    @(posedge clk); #1;
    bus0.dReq = 1; bus0.dWe = 1; bus0.dAddr = 32'h2000; bus0.dWdata = 32'hDEAD_BEEF;
    bus0.dataIn = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    checkVal("mid_bwe_before", 32'(bus0.busWriteEnable), 32'h1);
    reset = 1;
    #1;
    checkVal("mid_bwe_async", 32'(bus0.busWriteEnable), 32'h0);
    checkVal("mid_busy_async", 32'(bus0.busy), 32'h0);
    bus0.dReq = 0; bus0.dWe = 0;
    rstAck = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus0.dAck) rstAck++;
      if (i == 1) reset = 0;
    end
    checkVal("mid_noack", rstAck, 0);
    runTxn(1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0BAD_F00D, "reissue");

    // 6. back-to-back fetches on the zero-wait instance
    nAck = 0;
    ackAt1 = '{0, 0};
    got1 = '{32'h0, 32'h0};
    addrAt1 = 32'h0;
    @(posedge clk); #1;
    bus1.ifReq = 1; bus1.ifAddr = 32'h0; bus1.dataIn = 32'h1111_1111;
    @(posedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      seen1 = bus1.ifAck;
      if (seen1) begin
        if (nAck < 2) begin
          ackAt1[nAck] = cyc;
          got1[nAck] = bus1.ifData;
        end
        if (nAck == 1) addrAt1 = bus1.address;
        nAck++;
      end
      @(posedge clk); #1;
      if (seen1) begin
        if (nAck == 1) begin
          bus1.ifAddr = 32'h4; bus1.dataIn = 32'h2222_2222;
        end else begin
          bus1.ifReq = 0;
        end
      end
    end
    checkVal("b2b_count", nAck, 2);
    checkVal("b2b_ack0", ackAt1[0], 2);
    checkVal("b2b_ack1", ackAt1[1], 5);
    checkVal("b2b_data0", got1[0], 32'h1111_1111);
    checkVal("b2b_data1", got1[1], 32'h2222_2222);
    checkVal("b2b_addr1", addrAt1, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
